// File: rtl/wallace_mac_accumulator_if.sv
// wallace_mac_accumulator_if: operand-in / result-out handshake bundle; ACC_W must match the attached block
interface wallace_mac_accumulator_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             ovf;
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, ovf
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, ovf
  );
endinterface

// File: rtl/wallace_mac_accumulator.sv
// wallace_mac_accumulator: 3-stage multiply-accumulate over VEC_LEN operand pairs; define MAC_ACC_SATURATE_EN to clamp on overflow instead of wrapping
module eight_bit_wallace_tree (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] s
);
  logic [15:0] pp [8];
  logic [15:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
  // 3:2 compressor across a whole row; the dropped carry out of bit 15 is harmless since the product fits in 16 bits
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {16'(((x & y) | (x & z) | (y & z)) << 1), x ^ y ^ z};
  endfunction
  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = 16'({8'd0, a & {8{b[i]}}} << i);
  end
  assign {c1, s1} = csa(pp[0], pp[1], pp[2]);
  assign {c2, s2} = csa(pp[3], pp[4], pp[5]);
  assign {c3, s3} = csa(s1, c1, s2);
  assign {c4, s4} = csa(c2, pp[6], pp[7]);
  assign {c5, s5} = csa(s3, c3, s4);
  assign {c6, s6} = csa(s5, c5, c4);
  assign s = s6 + c6;
endmodule

module wallace_mac_accumulator #(
  parameter int VEC_LEN = 4,
  parameter int ACC_W   = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  wallace_mac_accumulator_if.slave   bus
);
  localparam int CW = $clog2(VEC_LEN);
  logic [7:0]       op_a, op_b;
  logic             op_vld, op_last;
  logic [15:0]      prod_s, prod;
  logic             prod_vld, prod_last;
  logic [CW-1:0]    cnt;
  logic             last_beat, accept;
  logic [ACC_W-1:0] acc, acc_nxt, result;
  logic [ACC_W:0]   sum;
  logic             carry, ovf_flag, ovf_nxt, ovf, out_valid;

  eight_bit_wallace_tree u_mul (.a(op_a), .b(op_b), .s(prod_s));

  assign last_beat     = cnt == CW'(VEC_LEN - 1);
  assign bus.in_ready  = ~((op_vld & op_last) | (prod_vld & prod_last) | out_valid) & ~clear;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.ovf       = ovf;

  // accumulator adder: carry out marks overflow; saturating build clamps, default build wraps
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, ACC_W'(prod)};
    carry   = sum[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
    acc_nxt = carry ? '1 : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
    ovf_nxt = ovf_flag | carry;
  end

  // stage 1: capture accepted operands, tag the final beat, advance the beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_vld  <= 1'b0;
      op_last <= 1'b0;
      cnt     <= '0;
    end else if (clear) begin
      op_vld  <= 1'b0;
      op_last <= 1'b0;
      cnt     <= '0;
    end else begin
      op_vld  <= accept;
      op_last <= accept & last_beat;
      if (accept) begin
        op_a <= bus.a;
        op_b <= bus.b;
        cnt  <= last_beat ? '0 : cnt + 1'b1;
      end
    end
  end

  // stage 2: register the tree product with its final-beat tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod      <= '0;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
    end else if (clear) begin
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
    end else begin
      prod_vld  <= op_vld;
      prod_last <= op_vld & op_last;
      if (op_vld) prod <= prod_s;
    end
  end

  // stage 3: accumulate; the final beat publishes result/ovf and restarts the vector from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf_flag  <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      ovf_flag  <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (prod_vld) begin
        acc      <= prod_last ? '0 : acc_nxt;
        ovf_flag <= ~prod_last & ovf_nxt;
      end
      if (prod_vld & prod_last) begin
        result <= acc_nxt;
        ovf    <= ovf_nxt;
      end
      out_valid <= (prod_vld & prod_last) | (out_valid & ~bus.out_ready);
    end
  end
endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// tb_wallace_mac_accumulator: directed and randomised MAC vectors checked against an exact-sum reference
module tb_wallace_mac_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic clear2 = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_ready = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wallace_mac_accumulator_if #(.ACC_W(24)) m4 ();
  wallace_mac_accumulator_if #(.ACC_W(16)) m2 ();

  wallace_mac_accumulator #(.VEC_LEN(4), .ACC_W(24)) dut (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(m4));
  wallace_mac_accumulator #(.VEC_LEN(2), .ACC_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .clear(clear2), .bus(m2));

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  typedef struct {longint r; longint o;} exp_t;
  exp_t exp_q[$];
  longint sum = 0;
  int nb = 0;
  int last_fin = 0;
  int n_res = 0;
  bit blocked = 0;
  bit just_hs = 0;
  bit prev_ov = 0;

  // reference: exact sum of products per vector, reduced to ACC_W bits only at the end
  always @(negedge clk) begin
    if (!rst_n || clear) begin
      sum = 0;
      nb = 0;
      exp_q.delete();
      blocked = 0;
      just_hs = 0;
      prev_ov = 0;
    end else begin
      if (just_hs) chk("ready_after_hs", m4.in_ready, 1);
      just_hs = 0;
      if (blocked) chk("ready_blocked", m4.in_ready, 0);
      if (m4.out_valid && !prev_ov) chk("latency", cyc - last_fin, 3);
      prev_ov = m4.out_valid;
      if (m4.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid got result 0x%0h expected no result", m4.result);
        end else begin
          chk("result", m4.result, exp_q[0].r);
          chk("ovf", m4.ovf, exp_q[0].o);
          if (m4.out_ready) begin
            void'(exp_q.pop_front());
            blocked = 0;
            just_hs = 1;
            n_res++;
          end
        end
      end
      if (m4.in_valid && m4.in_ready) begin
        sum += longint'(m4.a) * longint'(m4.b);
        nb++;
        if (nb == 4) begin
          exp_t e;
          longint mask = (longint'(1) << 24) - 1;
          e.o = (sum > mask) ? 1 : 0;
`ifdef MAC_ACC_SATURATE_EN
          e.r = e.o != 0 ? mask : sum;
`else
          e.r = sum & mask;
`endif
          exp_q.push_back(e);
          blocked = 1;
          last_fin = cyc;
          sum = 0;
          nb = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) m4.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, output int n);
    n = 0;
    m4.in_valid = 1'b1;
    m4.a = x;
    m4.b = y;
    do begin
      @(negedge clk);
      n++;
    end while (!m4.in_ready && n < 50);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    m4.in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!m4.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m4.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout got 0 expected 1");
    end
  endtask

  initial begin
    int n;
    int base;
    logic [15:0] r2;
    m4.in_valid = 0; m4.a = 0; m4.b = 0; m4.out_ready = 1;
    m2.in_valid = 0; m2.a = 0; m2.b = 0; m2.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", m4.result, 0);
    chk("rst_out_valid", m4.out_valid, 0);
    chk("rst_ovf", m4.ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", m4.in_ready, 1);
    @(posedge clk);
    #1;
    repeat (4) send(8'd255, 8'd255, n);
    wait_ov();
    chk("full_scale_result", m4.result, 24'h03F804);
    chk("full_scale_ovf", m4.ovf, 0);
    @(posedge clk);
    #1;
    m4.out_ready = 1'b0;
    send(8'd10, 8'd20, n);
    send(8'd30, 8'd40, n);
    send(8'd50, 8'd60, n);
    send(8'd70, 8'd80, n);
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      chk("held_result", m4.result, 24'h002710);
      chk("held_ready", m4.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    m4.out_ready = 1'b1;
    send(8'd10, 8'd20, n);
    chk("accept_after_hs", n, 2);
    send(8'd2, 8'd2, n);
    send(8'd3, 8'd3, n);
    send(8'd4, 8'd4, n);
    wait_ov();
    chk("after_hs_result", m4.result, 229);
    @(posedge clk);
    #1;
    send(8'd3, 8'd5, n);
    send(8'd7, 8'd9, n);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("cleared_no_valid", m4.out_valid, 0);
    end
    @(posedge clk);
    #1;
    repeat (4) send(8'd1, 8'd1, n);
    wait_ov();
    chk("after_clear_result", m4.result, 4);
    @(posedge clk);
    #1;
    send(8'd10, 8'd10, n);
    send(8'd10, 8'd10, n);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", m4.result, 0);
    chk("async_rst_valid", m4.out_valid, 0);
    chk("async_rst_ovf", m4.ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) send(8'd2, 8'd3, n);
    wait_ov();
    chk("after_rst_result", m4.result, 24);
    @(posedge clk);
    #1;
    chk("v2_ready", m2.in_ready, 1);
    m2.in_valid = 1'b1; m2.a = 8'd255; m2.b = 8'd255;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m2.in_valid = 1'b0;
    n = 0;
    while (!m2.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
`ifdef MAC_ACC_SATURATE_EN
    r2 = 16'hFFFF;
`else
    r2 = 16'hFC02;
`endif
    chk("v2_ovf_result", m2.result, r2);
    chk("v2_ovf_flag", m2.ovf, 1);
    @(posedge clk);
    #1;
    m2.in_valid = 1'b1; m2.a = 8'd1; m2.b = 8'd2;
    @(posedge clk);
    #1;
    m2.a = 8'd3; m2.b = 8'd4;
    @(posedge clk);
    #1;
    m2.in_valid = 1'b0;
    n = 0;
    while (!m2.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("v2_next_result", m2.result, 14);
    chk("v2_next_ovf", m2.ovf, 0);
    @(posedge clk);
    #1;
    base = n_res;
    rnd_ready = 1'b1;
    for (int v = 0; v < 100; v++) begin
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), n);
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    rnd_ready = 1'b0;
    m4.out_ready = 1'b1;
    chk("random_results", n_res - base, 100);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
